// File: rtl/ram128_arbiter.sv
// Two-requester front end for a single-port RAM: zero-fills the array after reset,
// then arbitrates round-robin between two valid/ready ports with a registered read response.
module ram128_arbiter #(
  parameter int unsigned Data_width = 32,
  parameter int unsigned Addr_width = 7,
  parameter bit          Init_en    = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  input  logic [1:0]            req_we_i,
  input  logic [Addr_width-1:0] req_addr0_i,
  input  logic [Addr_width-1:0] req_addr1_i,
  input  logic [Data_width-1:0] req_wdata0_i,
  input  logic [Data_width-1:0] req_wdata1_i,
  output logic [1:0]            req_ready_o,
  output logic [1:0]            rsp_valid_o,
  output logic [Data_width-1:0] rsp_rdata_o,
  output logic                  init_done_o,
  output logic                  ram_we_o,
  output logic [Addr_width-1:0] ram_addr_o,
  output logic [Data_width-1:0] ram_d_o,
  input  logic [Data_width-1:0] ram_q_i
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam state_e                  ResetState = Init_en ? StInit : StRun;
  localparam logic [Addr_width-1:0] LastAddr   = '1;

  state_e                  state_q, state_d;
  logic [Addr_width-1:0]   icnt_q, icnt_d;
  logic                    last_q, last_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [Data_width-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    init_done_q, init_done_d;
  logic [1:0]              grant;

  // Tie goes to the port that was not served last.
  always_comb begin
    grant = 2'b00;
    if (state_q == StRun) begin
      case (req_valid_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    last_d      = last_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_d_o     = '0;

    unique case (state_q)
      StInit: begin
        ram_we_o   = 1'b1;
        ram_addr_o = icnt_q;
        icnt_d     = icnt_q + 1'b1;
        if (icnt_q == LastAddr) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        init_done_d = 1'b1;
        if (grant[0]) begin
          ram_we_o   = req_we_i[0];
          ram_addr_o = req_addr0_i;
          ram_d_o    = req_wdata0_i;
          last_d     = 1'b0;
          rsp_valid_d[0] = ~req_we_i[0];
        end else if (grant[1]) begin
          ram_we_o   = req_we_i[1];
          ram_addr_o = req_addr1_i;
          ram_d_o    = req_wdata1_i;
          last_d     = 1'b1;
          rsp_valid_d[1] = ~req_we_i[1];
        end
        if (|rsp_valid_d) begin
          rsp_rdata_d = ram_q_i;
        end
      end
      default: state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ResetState;
      icnt_q      <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready_o = grant;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_ram128_arbiter.sv
// Bench for ram128_arbiter: behavioural RAM plus a reference model of grants, memory contents
// and read responses; directed scenarios followed by random traffic.
module tb_ram128_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00, req_we = 2'b00;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata, ram_d, ram_q;
  logic        init_done, ram_we;
  logic [6:0]  ram_addr;
  logic [31:0] ram [128];

  // Second instance without zero-fill.
  logic [1:0]  v2 = 2'b00, we2 = 2'b00;
  logic [6:0]  a2 = '0;
  logic [31:0] d2 = '0;
  logic [1:0]  ready2, rv2;
  logic [31:0] rd2, ram2_d, ram2_q;
  logic        done2, ram2_we;
  logic [6:0]  ram2_addr;
  logic [31:0] ram2 [128];

  always #5 clk = ~clk;

  ram128_arbiter #(.Data_width(32), .Addr_width(7), .Init_en(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .req_addr0_i(addr0), .req_addr1_i(addr1), .req_wdata0_i(wd0), .req_wdata1_i(wd1),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .init_done_o(init_done), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_d_o(ram_d),
    .ram_q_i(ram_q)
  );

  ram128_arbiter #(.Data_width(32), .Addr_width(7), .Init_en(1'b0)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_we_i(we2),
    .req_addr0_i(a2), .req_addr1_i(a2), .req_wdata0_i(d2), .req_wdata1_i(d2),
    .req_ready_o(ready2), .rsp_valid_o(rv2), .rsp_rdata_o(rd2),
    .init_done_o(done2), .ram_we_o(ram2_we), .ram_addr_o(ram2_addr), .ram_d_o(ram2_d),
    .ram_q_i(ram2_q)
  );

  always_ff @(posedge clk) if (ram_we) ram[ram_addr] <= ram_d;
  assign ram_q = ram[ram_addr];
  always_ff @(posedge clk) if (ram2_we) ram2[ram2_addr] <= ram2_d;
  assign ram2_q = ram2[ram2_addr];

  int          n_assert = 0;
  int          n_fail = 0;
  int          init_left;
  bit          m_last;
  logic [31:0] m_mem [128];
  logic [1:0]  e_rv;
  logic [31:0] e_rd;
  logic [1:0]  gq[$];
  bit          chk2_first = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_grant();
    if (init_left > 0 || req_valid == 2'b00) return 2'b00;
    if (req_valid != 2'b11) return req_valid;
    return m_last ? 2'b01 : 2'b10;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_init_done2", done2, 1'b0);
    init_left = 128;
    m_last    = 1'b1;
    e_rv      = 2'b00;
    e_rd      = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cycle();
    logic [1:0]  g;
    int          p;
    logic [6:0]  a;
    logic [31:0] d;
    @(negedge clk);
    g = exp_grant();
    p = g[1] ? 1 : 0;
    a = p ? addr1 : addr0;
    d = p ? wd1 : wd0;
    gq.push_back(g);
    chk("req_ready", req_ready, g);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("init_done", init_done, init_left == 0);
    if (init_left > 0) begin
      chk("init_we", ram_we, 1'b1);
      chk("init_addr", ram_addr, 128 - init_left);
      chk("init_d", ram_d, 0);
    end else if (g != 2'b00) begin
      chk("ram_we", ram_we, req_we[p]);
      chk("ram_addr", ram_addr, a);
      chk("ram_d", ram_d, d);
    end else begin
      chk("idle_we", ram_we, 1'b0);
      chk("idle_addr", ram_addr, 0);
      chk("idle_d", ram_d, 0);
    end
    if (chk2_first) chk("dut2_ready", ready2, 2'b01);
    @(posedge clk);
    e_rv = 2'b00;
    if (init_left > 0) begin
      m_mem[128 - init_left] = '0;
      init_left--;
    end else if (g != 2'b00) begin
      m_last = p[0];
      if (req_we[p]) m_mem[a] = d;
      else begin
        e_rv = g;
        e_rd = m_mem[a];
      end
    end
    #1;
    if (chk2_first) begin
      chk("dut2_init_done", done2, 1'b1);
      chk("dut2_ram", ram2[5], 32'hA5A5_0001);
      chk2_first = 1'b0;
      v2 = 2'b00;
    end
  endtask

  initial begin
    do_reset();
    // Zero-fill with both ports pending reads at 3 and 4, then round-robin.
    req_valid = 2'b11; req_we = 2'b00; addr0 = 7'd3; addr1 = 7'd4;
    v2 = 2'b01; we2 = 2'b01; a2 = 7'd5; d2 = 32'hA5A5_0001; chk2_first = 1'b1;
    repeat (128) cycle();
    for (int i = 0; i < 128; i++) chk("init_grant_none", gq[i], 2'b00);
    gq.delete();
    repeat (6) cycle();
    for (int i = 0; i < 6; i++) chk("rr_order", gq[i], (i % 2) ? 2'b10 : 2'b01);

    // Read 0x55 after fill.
    req_valid = 2'b01; req_we = 2'b00; addr0 = 7'h55;
    cycle();
    chk("read_55_valid", rsp_valid, 2'b01);
    chk("read_55_data", rsp_rdata, 0);

    // Write then read 0x7F.
    req_we = 2'b01; addr0 = 7'h7F; wd0 = 32'hDEAD_BEEF;
    cycle();
    req_we = 2'b00;
    cycle();
    chk("raw_valid", rsp_valid, 2'b01);
    chk("raw_data", rsp_rdata, 32'hDEAD_BEEF);

    // Port 1 streaming five reads.
    gq.delete();
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      addr1 = 7'h7B + 7'(i);
      cycle();
      chk("stream_rsp", rsp_valid, 2'b10);
    end
    for (int i = 0; i < 5; i++) chk("stream_ready", gq[i], 2'b10);
    req_valid = 2'b00;
    cycle();
    chk("stream_end", rsp_valid, 2'b00);

    // Reset mid-read.
    req_valid = 2'b01; addr0 = 7'h7F;
    cycle();
    chk("pre_rst_rsp", rsp_valid, 2'b01);
    do_reset();
    req_valid = 2'b11; addr0 = 7'd9; addr1 = 7'd10;
    repeat (130) cycle();

    // Random traffic on a narrow address range to exercise read-after-write.
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_we    = 2'($urandom_range(0, 3));
      addr0     = 7'($urandom_range(0, 7));
      addr1     = 7'($urandom_range(0, 7));
      wd0       = $urandom;
      wd1       = $urandom;
      cycle();
    end
    req_valid = 2'b00;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram128_arbiter.md
# ram128_arbiter

Two-requester controller for the single-port 128x32 RAM. It owns the RAM's `we`/`address`/`d` inputs and `q` output. After reset it sequences a zero-fill of every location. It then shares the RAM between two requesters using round-robin arbitration with a valid/ready request handshake and a registered read response. It sits directly in front of the RAM instance; requesters never drive the RAM themselves.

## Interface
Parameters:
- `Data_width`, 32, bits per word
- `Addr_width`, 7, address bits; depth = 2**Addr_width
- `Init_en`, 1, 1 = zero-fill all locations after reset; 0 = go straight to RUN

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid[1:0]`  in  2  per-port request valid
- `req_we[1:0]`  in  2  per-port 1 = write, 0 = read
- `req_addr0`, `req_addr1`  in  Addr_width  per-port address
- `req_wdata0`, `req_wdata1`  in  Data_width  per-port write data
- `req_ready[1:0]`  out  2  per-port grant; request is accepted when valid & ready
- `rsp_valid[1:0]`  out  2  per-port read-data valid, one-cycle pulse
- `rsp_rdata`  out  Data_width  read data, shared; qualified by `rsp_valid`
- `init_done`  out  1  high once zero-fill is complete
- `ram_we`  out  1  to RAM `we`
- `ram_addr`  out  Addr_width  to RAM `address`
- `ram_d`  out  Data_width  to RAM `d`
- `ram_q`  in  Data_width  from RAM `q`; combinational read of `ram_addr`

## Operation
- **States:** INIT, RUN.
  - Reset enters INIT if `Init_en` = 1, otherwise RUN.
- **INIT:**
  - Counter `icnt` starts at 0.
  - Each cycle: `ram_we` = 1, `ram_addr` = `icnt`, `ram_d` = 0, then `icnt`++.
  - After the write at `icnt` = 2**Addr_width-1, go to RUN.
  - `req_ready` = 00 throughout INIT.
- **RUN, arbitration (combinational):**
  - One valid: that port is granted.
  - Both valid: grant the port that is not `last`.
  - None valid: no grant.
  - `req_ready` is one-hot or 00.
  - `req_ready` may depend on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- **RUN, RAM drive:**
  - Granted port: `ram_we` = its `req_we`, `ram_addr` = its addr, `ram_d` = its wdata.
  - No grant: `ram_we` = 0, `ram_addr` = 0, `ram_d` = 0.
- **On accept:**
  - `last` <= granted port index.
  - For a read: `rsp_rdata` <= `ram_q` at that edge, and `rsp_valid[port]` <= 1 for the next cycle only.
  - Writes produce no response.
- **Back-to-back:** a port may issue a request every cycle.
- **Fairness:** with both ports continuously valid, grants alternate 0,1,0,1…

## Timing
- **Reset values (asserted asynchronously):**
  - Registers: state = INIT (or RUN), `icnt` = 0, `last` = 1 (port 0 wins the first tie).
  - Outputs: `rsp_valid` = 00, `rsp_rdata` = 0, `init_done` = 0.
- **`init_done`:**
  - Rises on the edge that writes the last location, so it is first high in the first RUN cycle.
  - Exactly 2**Addr_width cycles after reset release.
  - With `Init_en` = 0: high from reset release (0 after reset assertion, 1 from the first edge). It never falls outside reset.
- **Read latency:** `rsp_valid`/`rsp_rdata` valid the cycle after accept.
  - Read-after-write to the same address in consecutive accepts returns the new data.
  - A read and a write are never accepted in the same cycle.
- **`rsp_rdata`:** holds its last value when `rsp_valid` = 00.
- **Reset mid-operation:**
  - Pending responses are dropped: `rsp_valid` clears immediately.
  - INIT restarts from address 0.
  - Requests presented during reset or INIT are not accepted and must be held by the requester.
- **Address width:** no wrap beyond depth; `icnt` is Addr_width+1 bits or uses a terminal compare, so INIT ends exactly once.

## Test plan
- **Zero-fill:** release reset (`Init_en` = 1), hold `req_valid` = 11 → `req_ready` = 00 for 128 cycles with `ram_addr` stepping 0..127 and `ram_we` = 1. `init_done` = 1 on cycle 128; then reading address 0x55 returns 0.
- **Write then read:** port 0 writes 0xDEADBEEF to address 0x7F, next cycle port 0 reads 0x7F → `rsp_valid` = 01 one cycle later, `rsp_rdata` = 0xDEADBEEF.
- **Round-robin:** both ports hold valid reads (addresses 3 and 4) for 6 cycles starting from reset → grant order 0,1,0,1,0,1. `rsp_valid` alternates 01/10 one cycle delayed.
- **Single-port streaming:** only port 1 valid for 5 cycles → `req_ready` = 10 every cycle, 5 responses, no idle gaps.
- **Reset mid-read:** accept a port-0 read, assert `rst` before the next edge → `rsp_valid` = 00 immediately, no response after release, `init_done` = 0 and INIT restarts at address 0.
- **`Init_en` = 0:** first request is accepted on the first cycle after reset release; `init_done` = 1.
